// File: rtl/mem_ctrl_arbiter.sv
// Byte-serial memory port arbiter: MEM loads/stores take priority over IF fetches.
// Optional IO write throttling is enabled with `define MEM_CTRL_IO_STALL_EN.
module mem_ctrl_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy,
  input  logic                  inst_req_in,
  input  logic [ADDR_WIDTH-1:0] inst_addr_in,
  input  logic                  read_req_in,
  input  logic                  write_req_in,
  input  logic [ADDR_WIDTH-1:0] data_addr_in,
  input  logic [31:0]           data_val_in,
  input  logic [2:0]            store_len_in,
`ifdef MEM_CTRL_IO_STALL_EN
  input  logic                  io_buffer_full,
`endif
  output logic                  inst_done_out,
  output logic [31:0]           inst_out,
  output logic                  mem_done_out,
  output logic [31:0]           mem_val_read_out,
  output logic [1:0]            busy_out,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);

  localparam logic [2:0] LAT = 3'(RAM_LATENCY);

  typedef enum logic [2:0] {IDLE, IF_RD, D_RD, D_WR, DONE} state_t;

  state_t                  state, state_nxt;
  logic [2:0]              cnt, cnt_nxt;
  logic [2:0]              len;
  logic                    is_inst;
  logic [31:0]             result;
  logic [ADDR_WIDTH-1:0]   base;
  logic [31:0]             wdata;
  logic [2:0]              offs;
  logic                    take_wr, take_rd, take_if, capture;
  logic                    idle_io_wait, wr_stall;

`ifdef MEM_CTRL_IO_STALL_EN
  logic io_store;

  assign idle_io_wait = write_req_in && (data_addr_in[17:16] == 2'b11) && io_buffer_full;
  assign wr_stall     = io_store && io_buffer_full;
`else
  assign idle_io_wait = 1'b0;
  assign wr_stall     = 1'b0;
`endif

  // Read states count one extra cycle past the last address so the final byte lands.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take_wr   = 1'b0;
    take_rd   = 1'b0;
    take_if   = 1'b0;
    capture   = 1'b0;
    if (rdy) begin
      case (state)
        IDLE: begin
          cnt_nxt = 3'd0;
          if (write_req_in) begin
            if (!idle_io_wait) begin
              take_wr   = 1'b1;
              state_nxt = D_WR;
            end
          end else if (read_req_in) begin
            take_rd   = 1'b1;
            state_nxt = D_RD;
          end else if (inst_req_in) begin
            take_if   = 1'b1;
            state_nxt = IF_RD;
          end
        end
        IF_RD, D_RD: begin
          if (state == IF_RD && (read_req_in || write_req_in)) begin
            state_nxt = IDLE;
            cnt_nxt   = 3'd0;
          end else begin
            capture = (cnt >= LAT);
            if (cnt == len + LAT - 3'd1) begin
              state_nxt = DONE;
              cnt_nxt   = 3'd0;
            end else begin
              cnt_nxt = cnt + 3'd1;
            end
          end
        end
        D_WR: begin
          if (!wr_stall) begin
            if (cnt == len - 3'd1) begin
              state_nxt = DONE;
              cnt_nxt   = 3'd0;
            end else begin
              cnt_nxt = cnt + 3'd1;
            end
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // While frozen, point the RAM at the byte awaiting capture so it is on mem_din when rdy returns.
  always_comb begin
    mem_wr        = 1'b0;
    mem_a         = '0;
    mem_dout      = 8'h00;
    busy_out      = 2'b00;
    inst_done_out = 1'b0;
    mem_done_out  = 1'b0;
    offs          = cnt;
    case (state)
      IDLE: begin
        if (idle_io_wait) busy_out = 2'b10;
      end
      IF_RD, D_RD: begin
        busy_out = (state == IF_RD) ? 2'b01 : 2'b10;
        if (!rdy && cnt >= LAT) offs = cnt - LAT;
        mem_a = base + {{(ADDR_WIDTH-3){1'b0}}, offs};
      end
      D_WR: begin
        busy_out = 2'b10;
        mem_a    = base + {{(ADDR_WIDTH-3){1'b0}}, cnt};
        mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
        mem_wr   = rdy && !wr_stall;
      end
      DONE: begin
        inst_done_out = rdy && is_inst;
        mem_done_out  = rdy && !is_inst;
      end
      default: ;
    endcase
  end

  assign inst_out         = result;
  assign mem_val_read_out = result;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      len     <= 3'd0;
      is_inst <= 1'b0;
      result  <= 32'h0;
`ifdef MEM_CTRL_IO_STALL_EN
      io_store <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (take_wr) begin
        len     <= store_len_in + 3'd1;
        is_inst <= 1'b0;
        result  <= 32'h0;
`ifdef MEM_CTRL_IO_STALL_EN
        io_store <= (data_addr_in[17:16] == 2'b11);
`endif
      end
      if (take_rd) begin
        len     <= store_len_in;
        is_inst <= 1'b0;
        result  <= 32'h0;
      end
      if (take_if) begin
        len     <= 3'd4;
        is_inst <= 1'b1;
        result  <= 32'h0;
      end
      for (int b = 0; b < 4; b++) begin
        if (capture && cnt == 3'(b) + LAT) result[8*b +: 8] <= mem_din;
      end
    end
  end

  // Address and store data are only meaningful inside a transfer, so they carry no reset.
  always_ff @(posedge clk_in) begin
    if (take_wr) begin
      base  <= data_addr_in;
      wdata <= data_val_in;
    end else if (take_rd) begin
      base <= data_addr_in;
    end else if (take_if) begin
      base <= inst_addr_in;
    end
  end

endmodule

// File: doc/mem_ctrl_arbiter.md
Name: mem_ctrl_arbiter

Overview:
- Sits between the IF and MEM pipeline stages and the single byte-wide RAM/IO port.
- Serialises 1/2/4-byte loads, stores and 4-byte instruction fetches into byte transfers.
- Arbitrates the two requesters; MEM has priority.
- Returns assembled little-endian words with a one-cycle done pulse and exposes a 2-bit busy code that MEM uses to decide when to issue requests.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- RAM_LATENCY, 1, cycles from address presented to read byte valid on mem_din; fixed at 1, other values unsupported.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy  input  1  global enable; when low, all state holds and mem_wr is driven 0.
- inst_req_in  input  1  IF fetch request, level, held until inst_done_out.
- inst_addr_in  input  ADDR_WIDTH  fetch address.
- read_req_in  input  1  MEM load request.
- write_req_in  input  1  MEM store request.
- data_addr_in  input  ADDR_WIDTH  load/store address.
- data_val_in  input  32  store data, little-endian, low bytes used.
- store_len_in  input  3  loads: byte count (1/2/4); stores: byte count minus 1 (0/1/3).
- inst_done_out  output  1  one-cycle pulse, fetch complete.
- inst_out  output  32  fetched word, valid with inst_done_out.
- mem_done_out  output  1  one-cycle pulse, load/store complete.
- mem_val_read_out  output  32  load data, zero-extended, valid with mem_done_out.
- busy_out  output  2  00 idle; 01 serving IF; 10 serving MEM; 11 unused.
- mem_din  input  8  byte from RAM.
- mem_dout  output  8  byte to RAM.
- mem_a  output  ADDR_WIDTH  byte address to RAM.
- mem_wr  output  1  1 = write, 0 = read.

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE, byte counter 0, and every output 0, including inst_out, mem_val_read_out, mem_a, mem_dout and mem_wr.
- States: IDLE, IF_RD, D_RD, D_WR, DONE.
- Arbitration in IDLE: write_req_in > read_req_in > inst_req_in.
  - The chosen request and its length are latched: fetch = 4 bytes; load = store_len_in; store = store_len_in+1.
  - Address and data are latched at acceptance.
  - Go to D_WR, D_RD or IF_RD.
- D_WR: each cycle drives mem_wr=1, mem_a=base+k, mem_dout=data byte k. After the last byte goes to DONE. Latency: N cycles, then done pulse in DONE.
- D_RD / IF_RD:
  - Cycle k drives mem_wr=0, mem_a=base+k.
  - Byte k is captured from mem_din in cycle k+1 into result[8k+7:8k].
  - The address phase and capture phase overlap.
  - Done pulse in the cycle after the last byte is captured: 4-byte read = 6 cycles from acceptance to pulse.
- DONE:
  - Asserts exactly one of inst_done_out or mem_done_out for one cycle, with assembled data; unread upper bytes are 0.
  - mem_wr=0, then IDLE.
  - A requester still asserted in the DONE cycle is not re-accepted until the following IDLE cycle.
- Preemption:
  - A MEM request (read or write) arriving while in IF_RD aborts the fetch at the end of the current cycle; partial fetch data is discarded and no inst_done_out is given.
  - The MEM request is accepted in the next cycle via IDLE, and the fetch restarts from byte 0 afterwards.
  - MEM transfers are never preempted.
- busy_out: 01 in IF_RD; 10 in D_RD and D_WR; 00 in IDLE and DONE.
- Address increment is ADDR_WIDTH-bit and wraps modulo 2^ADDR_WIDTH.
- mem_wr must be 0 in every cycle that is not a D_WR byte cycle.
- rdy low mid-transfer: freezes counter and state, and forces mem_wr=0. The byte in flight on mem_din is captured on the first cycle rdy returns high; the address is re-presented one cycle earlier.
- Reset mid-transfer: aborts immediately; no done pulse is issued.

Optional Feature:
- Macro: MEM_CTRL_IO_STALL_EN.
- When defined:
  - Adds input io_buffer_full (1 bit).
  - A store whose data_addr_in[17:16]==2'b11 waits in IDLE while io_buffer_full is high; busy_out reads 10 during the wait.
  - Each such byte cycle in D_WR also stalls (mem_wr=0) while io_buffer_full is high.
- When undefined: no such port; IO writes proceed unthrottled.

Test Plan:
- 4-byte fetch at 0x00000100, RAM bytes 13 05 00 00 → inst_done_out pulse 6 cycles after acceptance, inst_out=0x00000513, busy_out=01 throughout.
- Load store_len_in=2 at 0x1002, RAM bytes AB CD → mem_done_out pulse after 4 cycles, mem_val_read_out=0x0000CDAB.
- Store store_len_in=3, data 0xDEADBEEF at 0x2000 → mem_wr=1 on four consecutive cycles at 0x2000..0x2003 with bytes EF BE AD DE; mem_done_out next cycle.
- Fetch in progress (byte 1 captured) when read_req_in rises → fetch aborted, no inst_done_out, busy_out 10 next-next cycle; fetch then restarts and completes with correct word.
- rst_in pulsed low mid-store → mem_wr drops to 0 asynchronously, no mem_done_out, state IDLE, all outputs 0.
- With MEM_CTRL_IO_STALL_EN defined: SB to 0x30000 while io_buffer_full=1 for 5 cycles → no mem_wr during the hold; write of the byte on the first cycle io_buffer_full=0, then done pulse.
